simon_data_out: RTL and testbench
=================================

SIMON_DATA_OUT -- requirements
Module: simon_data_out

Interface
REQ-001 The block SHALL use macro N (default 16), the cipher word width in bits, taken from SIMON_defintions.svh.
REQ-002 The block SHALL use macro MODE (default 4'h0), the mode code written to info[3:0], taken from SIMON_defintions.svh.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port nR, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port newOUT, input, 1 bit: the cipher holds a result block; held high until loadOUT is seen.
REQ-006 The block SHALL have port outDATA, input, [1:0][N-1:0]: the result block, word 0 then word 1.
REQ-007 The block SHALL have port infoOUT, input, 8 bits: the info byte of the originating input packet; bit7 means two blocks per packet.
REQ-008 The block SHALL have port loadOUT, output, 1 bit: acknowledge that the result block has been taken.
REQ-009 The block SHALL have port out, output, [(1+N/2):0][7:0]: the output packet; bytes N/2-1..0 are data, byte N/2 is count, byte N/2+1 is info.
REQ-010 The block SHALL have port newPKT, output, 1 bit: output packet valid.
REQ-011 The block SHALL have port loadPKT, input, 1 bit: the consumer has accepted the packet.

Function
REQ-012 The state machine SHALL have four states: IDLE, COLLECT, BUILD and SEND.
REQ-013 IDLE SHALL capture a block when newOUT=1 and loadOUT=0 at an edge, set loadOUT=1 and store infoOUT; next state is COLLECT if infoOUT[7]=1, otherwise BUILD.
REQ-014 loadOUT SHALL stay high until newOUT is sampled low, then clear on that edge; no block SHALL be captured while loadOUT=1.
REQ-015 COLLECT SHALL wait for the next newOUT=1 with loadOUT=0, capture the second block with the same ack rule, then go to BUILD; the second block's infoOUT is ignored.
REQ-016 For a two-block packet, the first block SHALL fill data words 0,1 and the second block words 2,3.
REQ-017 For a one-block packet, the block SHALL fill data words 2,3 and words 0,1 SHALL be zero.
REQ-018 Data word k SHALL occupy packet bytes [(k+1)*N/8-1 : k*N/8].
REQ-019 Info byte SHALL be: [3:0]=MODE, [4]=1 (output packet), [5]=0, [6]=0, [7]=stored infoOUT[7].
REQ-020 Count byte SHALL equal the internal packet counter, 8 bits, wrapping 255->0.
REQ-021 BUILD SHALL take one cycle: register out, set newPKT=1, go to SEND; latency from last capture edge to newPKT high is 1 cycle.
REQ-022 SEND SHALL hold out and newPKT stable until loadPKT is sampled high; on that edge newPKT<=0, counter increments, next state IDLE.
REQ-023 New blocks SHALL NOT be captured in BUILD or SEND (back-pressure); at most one packet is buffered.
REQ-024 loadPKT high outside SEND SHALL be ignored.
REQ-025 newOUT and loadPKT high on the same edge in SEND SHALL complete the send only; the block is captured in IDLE on a later edge.

Reset
REQ-026 On nR low, immediately: out=0, newPKT=0, loadOUT=0, counter=0, stored info=0, state=IDLE.
REQ-027 Reset mid-operation SHALL discard any partial or pending packet; after release, the count restarts at 0.

Configuration
REQ-028 Macro SIMON_DATA_OUT_ERR_EN SHALL control block checking.
REQ-029 With SIMON_DATA_OUT_ERR_EN defined: an extra output err (1 bit) SHALL exist, reset to 0 and sticky until reset.
REQ-030 With SIMON_DATA_OUT_ERR_EN defined: err SHALL set when a first block is captured with infoOUT[3:0]!=MODE or infoOUT[5]=1; that block SHALL still be acknowledged but dropped, and the state stays IDLE.
REQ-031 Without SIMON_DATA_OUT_ERR_EN: no err port, no check, and every captured block SHALL be packed.

Verification
REQ-032 Single block (N=16): infoOUT=8'h00, outDATA={16'hBEEF,16'h1234} -> after 1 cycle newPKT=1; out data bytes = 0x0000_0000 for words 0,1 and words 2,3 = 0x1234,0xBEEF; count=0x00; info=0x10.
REQ-033 Two blocks: infoOUT=8'h80 with {16'h0002,16'h0001}, then {16'h0004,16'h0003} -> words 0..3 = 1,2,3,4; info=0x90; no packet after the first block.
REQ-034 Back-pressure: loadPKT held low for 10 cycles while newOUT=1 -> loadOUT stays 0 and out stays stable; loadPKT=1 -> newPKT falls next edge and the block is captured afterwards.
REQ-035 Wrap: send 256 single-block packets -> count bytes 0x00..0xFF, and the 257th packet has count 0x00.
REQ-036 Reset asserted in COLLECT after first block -> outputs 0 immediately; next packet after release has count 0x00 and contains only new data.
REQ-037 With SIMON_DATA_OUT_ERR_EN: infoOUT[3:0]!=MODE -> loadOUT pulses, err=1, no newPKT; the following valid block is packed normally.

Source files
------------

// File: rtl/simon_data_out.sv
// SIMON result packer: gathers one or two cipher result blocks into an output packet.
// Optional build macro SIMON_DATA_OUT_ERR_EN adds a sticky err flag and drops malformed first blocks.
`ifndef N
`define N 16
`endif
`ifndef MODE
`define MODE 4'h0
`endif

module simon_data_out (
    input  logic                        clk,
    input  logic                        nR,
    input  logic                        newOUT,
    input  logic [1:0][`N-1:0]          outDATA,
    input  logic [7:0]                  infoOUT,
    output logic                        loadOUT,
    output logic [(1+`N/2):0][7:0]      out,
    output logic                        newPKT,
    input  logic                        loadPKT,
`ifdef SIMON_DATA_OUT_ERR_EN
    output logic                        err,
`endif
    output logic [1:0]                  o_dbg_state
);

    localparam int         NW     = `N;
    localparam logic [3:0] MODE_C = `MODE;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_BUILD   = 2'd2;
    localparam logic [1:0] S_SEND    = 2'd3;

    logic [1:0]             r_state;
    logic [3:0][NW-1:0]     r_data;
    logic                   r_two_blk;
    logic [7:0]             r_cnt;
    logic                   r_load_out;
    logic                   r_new_pkt;
    logic [(1+NW/2):0][7:0] r_out;

    logic       w_take;
    logic       w_bad;
    logic [7:0] w_info;
    logic       w_unused;

    // Handshake: a block is taken only on an edge with newOUT high and no ack outstanding.
    assign w_take   = newOUT && !r_load_out;
    assign w_info   = {r_two_blk, 2'b00, 1'b1, MODE_C};
    assign w_unused = ^infoOUT[6:0];

`ifdef SIMON_DATA_OUT_ERR_EN
    logic r_err;

    assign w_bad = (infoOUT[3:0] != MODE_C) || infoOUT[5];
    assign err   = r_err;

    always_ff @(posedge clk or negedge nR) begin
        if (!nR)
            r_err <= 1'b0;
        else if (r_state == S_IDLE && w_take && w_bad)
            r_err <= 1'b1;
    end
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_two_blk  <= 1'b0;
            r_cnt      <= 8'd0;
            r_load_out <= 1'b0;
            r_new_pkt  <= 1'b0;
            r_out      <= '0;
        end else begin
            if (r_load_out && !newOUT)
                r_load_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_load_out <= 1'b1;
                        // A rejected block is acknowledged but leaves the FSM in IDLE.
                        if (!w_bad) begin
                            r_two_blk <= infoOUT[7];
                            if (infoOUT[7]) begin
                                r_data[0] <= outDATA[0];
                                r_data[1] <= outDATA[1];
                                r_state   <= S_COLLECT;
                            end else begin
                                r_data[0] <= '0;
                                r_data[1] <= '0;
                                r_data[2] <= outDATA[0];
                                r_data[3] <= outDATA[1];
                                r_state   <= S_BUILD;
                            end
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_take) begin
                        r_load_out <= 1'b1;
                        r_data[2]  <= outDATA[0];
                        r_data[3]  <= outDATA[1];
                        r_state    <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    r_out     <= {w_info, r_cnt, r_data};
                    r_new_pkt <= 1'b1;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (loadPKT) begin
                        r_new_pkt <= 1'b0;
                        r_cnt     <= r_cnt + 8'd1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign loadOUT     = r_load_out;
    assign newPKT      = r_new_pkt;
    assign out         = r_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_simon_data_out.sv
// Directed bench for simon_data_out: single/two-block packing, back-pressure, count wrap, reset, optional err.
`ifndef N
`define N 16
`endif

module tb_simon_data_out;

    localparam int W  = `N;
    localparam int PW = 4 * W + 16;

    logic                   clk;
    logic                   nR;
    logic                   newOUT;
    logic [1:0][W-1:0]      outDATA;
    logic [7:0]             infoOUT;
    logic                   loadOUT;
    logic [(1+W/2):0][7:0]  out;
    logic                   newPKT;
    logic                   loadPKT;
    logic [1:0]             dbg_state;
`ifdef SIMON_DATA_OUT_ERR_EN
    logic                   err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    simon_data_out dut (
        .clk         (clk),
        .nR          (nR),
        .newOUT      (newOUT),
        .outDATA     (outDATA),
        .infoOUT     (infoOUT),
        .loadOUT     (loadOUT),
        .out         (out),
        .newPKT      (newPKT),
        .loadPKT     (loadPKT),
`ifdef SIMON_DATA_OUT_ERR_EN
        .err         (err),
`endif
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] exp_pkt(input logic [7:0] info, input logic [7:0] cnt,
                                              input logic [W-1:0] w0, input logic [W-1:0] w1,
                                              input logic [W-1:0] w2, input logic [W-1:0] w3);
        return {info, cnt, w3, w2, w1, w0};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_block(input logic [7:0] info, input logic [W-1:0] w0, input logic [W-1:0] w1);
        int k;
        newOUT     = 1'b1;
        infoOUT    = info;
        outDATA[0] = w0;
        outDATA[1] = w1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!loadOUT && k < 8);
        check("ack_seen", loadOUT, 1);
        newOUT = 1'b0;
    endtask

    task automatic accept();
        loadPKT = 1'b1;
        tick();
        check("accept_drop", newPKT, 0);
        loadPKT = 1'b0;
    endtask

    task automatic do_reset();
        nR = 1'b0;
        #3;
        @(negedge clk);
        nR = 1'b1;
        tick();
    endtask

    logic [PW-1:0] held;

    initial begin
        nR      = 1'b0;
        newOUT  = 1'b0;
        outDATA = '0;
        infoOUT = 8'h00;
        loadPKT = 1'b0;
        do_reset();

        check("rst_out", out, 0);
        check("rst_newpkt", newPKT, 0);
        check("rst_loadout", loadOUT, 0);
        check("rst_state", dbg_state, 0);
`ifdef SIMON_DATA_OUT_ERR_EN
        check("rst_err", err, 0);
`endif

        // single block goes to words 2,3
        put_block(8'h00, 16'h1234, 16'hBEEF);
        check("single_lat0", newPKT, 0);
        tick();
        check("single_newpkt", newPKT, 1);
        check("single_ack_clr", loadOUT, 0);
        check("single_out", out, exp_pkt(8'h10, 8'h00, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF));
        accept();

        // two-block packet
        put_block(8'h80, 16'h0001, 16'h0002);
        tick();
        check("two_nopkt_a", newPKT, 0);
        check("two_ack_clr", loadOUT, 0);
        put_block(8'h05, 16'h0003, 16'h0004);
        check("two_nopkt_b", newPKT, 0);
        tick();
        check("two_newpkt", newPKT, 1);
        check("two_out", out, exp_pkt(8'h90, 8'h01, 16'h0001, 16'h0002, 16'h0003, 16'h0004));
        accept();

        // back-pressure while a packet is pending
        put_block(8'h00, 16'h5555, 16'hAAAA);
        tick();
        held = exp_pkt(8'h10, 8'h02, 16'h0000, 16'h0000, 16'h5555, 16'hAAAA);
        check("bp_first", out, held);
        newOUT     = 1'b1;
        infoOUT    = 8'h00;
        outDATA[0] = 16'hDDDD;
        outDATA[1] = 16'hCCCC;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_noack", loadOUT, 0);
            check("bp_hold_pkt", newPKT, 1);
            check("bp_hold_out", out, held);
        end
        loadPKT = 1'b1;
        tick();
        loadPKT = 1'b0;
        check("bp_release", newPKT, 0);
        check("bp_no_same_edge", loadOUT, 0);
        tick();
        check("bp_capture", loadOUT, 1);
        newOUT = 1'b0;
        tick();
        check("bp_second_pkt", newPKT, 1);
        check("bp_second_out", out, exp_pkt(8'h10, 8'h03, 16'h0000, 16'h0000, 16'hDDDD, 16'hCCCC));
        accept();

        // loadPKT outside SEND must not bump the count
        loadPKT = 1'b1;
        tick();
        tick();
        tick();
        loadPKT = 1'b0;
        check("idle_loadpkt", newPKT, 0);
        put_block(8'h00, 16'h0101, 16'h0202);
        tick();
        check("idle_loadpkt_out", out, exp_pkt(8'h10, 8'h04, 16'h0000, 16'h0000, 16'h0101, 16'h0202));
        accept();

        // reset in COLLECT discards the partial packet
        put_block(8'h80, 16'h1111, 16'h2222);
        check("collect_state", dbg_state, 1);
        #2;
        nR = 1'b0;
        #1;
        check("midrst_loadout", loadOUT, 0);
        check("midrst_newpkt", newPKT, 0);
        check("midrst_out", out, 0);
        check("midrst_state", dbg_state, 0);
        @(negedge clk);
        nR = 1'b1;
        tick();
        put_block(8'h00, 16'h3333, 16'h4444);
        tick();
        check("midrst_pkt", out, exp_pkt(8'h10, 8'h00, 16'h0000, 16'h0000, 16'h3333, 16'h4444));
        accept();

        // count wrap over 257 packets
        do_reset();
        for (int i = 0; i < 257; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            put_block(8'h00, W'(iv), W'(~iv));
            tick();
            check("wrap_pkt", out, exp_pkt(8'h10, iv[7:0], '0, '0, W'(iv), W'(~iv)));
            accept();
        end

`ifdef SIMON_DATA_OUT_ERR_EN
        // malformed first block: acked, flagged, dropped
        check("err_pre", err, 0);
        put_block(8'h03, 16'h9999, 16'h8888);
        check("err_set", err, 1);
        tick();
        check("err_nopkt", newPKT, 0);
        check("err_idle", dbg_state, 0);
        check("err_ack_clr", loadOUT, 0);
        put_block(8'h20, 16'h9999, 16'h8888);
        tick();
        check("err_bit5_nopkt", newPKT, 0);
        put_block(8'h00, 16'h7777, 16'h6666);
        tick();
        check("err_next_pkt", newPKT, 1);
        check("err_next_out", out, exp_pkt(8'h10, 8'h01, 16'h0000, 16'h0000, 16'h7777, 16'h6666));
        check("err_sticky", err, 1);
        accept();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
